// File: rtl/audio_peak_hex_source_if.sv
// Sample stream from the effects pipeline into the hex display source.
interface audio_peak_hex_source_if;
  logic        sample_valid;
  logic [15:0] sample;

  modport master (output sample_valid, output sample);
  modport slave  (input  sample_valid, input  sample);
endinterface

// File: rtl/audio_peak_hex_source.sv
// Peak-hold/decay tracker feeding four hex digits; display refreshes every REFRESH_CYCLES, no backpressure.
// Optional sticky clip indicator built only when AUDIO_PEAK_CLIP_EN is defined.
module audio_peak_hex_source #(
  parameter int unsigned HOLD_CYCLES    = 1024,
  parameter int unsigned DECAY_CYCLES   = 64,
  parameter logic [15:0] DECAY_STEP     = 16'd16,
  parameter int unsigned REFRESH_CYCLES = 4096,
  parameter logic [15:0] CLIP_THRESH    = 16'h7F00
) (
  input  logic                           Clk,
  input  logic                           Reset_n,
  audio_peak_hex_source_if.slave         smp,
  input  logic                           peak_mode,
  input  logic                           clear,
  output logic [3:0]                     Hex0,
  output logic [3:0]                     Hex1,
  output logic [3:0]                     Hex2,
  output logic [3:0]                     Hex3,
  output logic                           disp_update,
  output logic                           clip_led
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int DW = $clog2(DECAY_CYCLES + 1);
  localparam int RW = $clog2(REFRESH_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [DW-1:0] DEC_LAST  = DW'(DECAY_CYCLES - 1);
  localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, DECAY} state_e;

  state_e        state_q, state_d;
  logic [15:0]   peak_q, peak_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [DW-1:0] dec_cnt_q, dec_cnt_d;
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic [15:0]   live_q, live_d;
  logic [15:0]   disp_q, disp_d;
  logic          upd_q, upd_d;

  logic [15:0] abs_val;
  logic [15:0] decayed;
  logic [15:0] disp_src;
  logic        new_peak;
  logic        hold_done;
  logic        decay_tick;
  logic        ref_tc;

  // -32768 has no positive counterpart, so it pins to full scale
  always_comb begin
    abs_val = smp.sample;
    if (smp.sample == 16'h8000) abs_val = 16'h7FFF;
    else if (smp.sample[15])    abs_val = -smp.sample;
  end

  assign new_peak = smp.sample_valid && (abs_val > peak_q);
  assign decayed  = (peak_q > DECAY_STEP) ? (peak_q - DECAY_STEP) : 16'h0000;
  assign ref_tc   = (ref_cnt_q == REF_LAST);
  assign disp_src = peak_mode ? peak_q : live_q;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      peak_q     <= '0;
      hold_cnt_q <= '0;
      dec_cnt_q  <= '0;
      ref_cnt_q  <= '0;
      live_q     <= '0;
      disp_q     <= '0;
      upd_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      peak_q     <= peak_d;
      hold_cnt_q <= hold_cnt_d;
      dec_cnt_q  <= dec_cnt_d;
      ref_cnt_q  <= ref_cnt_d;
      live_q     <= live_d;
      disp_q     <= disp_d;
      upd_q      <= upd_d;
    end
  end

  // A louder sample always wins over hold expiry or a decay tick
  always_comb begin
    state_d    = state_q;
    peak_d     = peak_q;
    hold_cnt_d = hold_cnt_q;
    dec_cnt_d  = dec_cnt_q;
    if (clear) begin
      state_d    = IDLE;
      peak_d     = '0;
      hold_cnt_d = '0;
      dec_cnt_d  = '0;
    end else if (new_peak) begin
      state_d    = HOLD;
      peak_d     = abs_val;
      hold_cnt_d = '0;
      dec_cnt_d  = '0;
    end else begin
      case (state_q)
        HOLD: begin
          if (hold_done) begin
            state_d   = DECAY;
            dec_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        DECAY: begin
          if (decay_tick) begin
            peak_d    = decayed;
            dec_cnt_d = '0;
            if (decayed == 16'h0000) state_d = IDLE;
          end else begin
            dec_cnt_d = dec_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    hold_done  = (state_q == HOLD)  && (hold_cnt_q == HOLD_LAST);
    decay_tick = (state_q == DECAY) && (dec_cnt_q == DEC_LAST);
  end

  always_comb begin
    live_d    = live_q;
    disp_d    = disp_q;
    upd_d     = 1'b0;
    ref_cnt_d = ref_tc ? '0 : ref_cnt_q + 1'b1;
    if (clear) begin
      disp_d    = '0;
      ref_cnt_d = '0;
    end else begin
      if (smp.sample_valid) live_d = smp.sample;
      if (ref_tc) begin
        disp_d = disp_src;
        upd_d  = (disp_src != disp_q);
      end
    end
  end

  assign Hex0        = disp_q[3:0];
  assign Hex1        = disp_q[7:4];
  assign Hex2        = disp_q[11:8];
  assign Hex3        = disp_q[15:12];
  assign disp_update = upd_q;

`ifdef AUDIO_PEAK_CLIP_EN
  logic clip_q, clip_d;

  always_comb begin
    clip_d = clip_q;
    if (clear)                                            clip_d = 1'b0;
    else if (smp.sample_valid && (abs_val >= CLIP_THRESH)) clip_d = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) clip_q <= 1'b0;
    else          clip_q <= clip_d;
  end

  assign clip_led = clip_q;
`else
  // Threshold only matters when the clip logic is built; output is constant 0
  assign clip_led = 1'b0 & (^CLIP_THRESH);
`endif

endmodule

// File: doc/audio_peak_hex_source.md
Name: audio_peak_hex_source

Overview:
- Upstream stage for the four 7-segment hex decoders on the audio effects board.
- Accepts the 16-bit signed sample stream from the effects pipeline and tracks a peak-hold/decay level of |sample|.
- Presents a rate-limited 16-bit display word, split into four 4-bit nibbles, one per hex decoder.
- Mode input selects either the live raw sample or the held peak for display.

Parameters:
- HOLD_CYCLES, 1024: clocks a new peak is held before decay begins (≥1).
- DECAY_CYCLES, 64: clocks between successive decay decrements (≥1).
- DECAY_STEP, 16: amount subtracted from the peak per decay tick (16-bit, ≥1).
- REFRESH_CYCLES, 4096: clocks between display word updates (≥1).
- CLIP_THRESH, 16'h7F00: |sample| at or above this value sets the clip flag (optional feature only).

Ports:
- Clk  input  1  system clock; all logic is on the rising edge.
- Reset_n  input  1  synchronous, active-low reset.
- sample_valid  input  1  qualifies sample for one clock.
- sample  input  16  signed two's-complement audio sample.
- peak_mode  input  1  0 = display live sample, 1 = display held peak.
- clear  input  1  synchronous clear of the peak, hold state and clip flag.
- Hex0  output  4  display word [3:0].
- Hex1  output  4  display word [7:4].
- Hex2  output  4  display word [11:8].
- Hex3  output  4  display word [15:12].
- disp_update  output  1  one-clock pulse in the cycle after the display word changes source value.
- clip_led  output  1  sticky clip indicator (only with the optional feature; otherwise tied 0).

Behaviour:
- Reset (Reset_n=0 at a clock edge): peak=0, live=0, state=IDLE, all counters=0, Hex0–3=0, disp_update=0, clip_led=0. Reset overrides every other input, including mid-hold and mid-decay.
- Absolute value: abs = sample[15] ? -sample : sample. The value 16'h8000 saturates to 16'h7FFF. abs is always at most 16'h7FFF.
- Live register: on sample_valid, live <= sample (raw, not abs).
- Peak FSM has three states: IDLE, HOLD, DECAY.
  - Any state, sample_valid with abs > peak: peak <= abs, hold_cnt <= 0, go to HOLD. This takes priority over decay and hold expiry in the same cycle.
  - An equal sample (abs == peak) does not restart the hold.
  - IDLE: peak == 0; wait for a sample.
  - HOLD: hold_cnt increments each clock. At hold_cnt == HOLD_CYCLES-1, go to DECAY with dec_cnt <= 0.
  - DECAY: dec_cnt increments each clock. At dec_cnt == DECAY_CYCLES-1: peak <= (peak > DECAY_STEP) ? peak-DECAY_STEP : 0 (no underflow), and dec_cnt <= 0. If the result is 0, go to IDLE.
- clear: state=IDLE, peak=0, counters=0, clip_led=0. live is not affected. Reset still has priority over clear; clear has priority over sample capture in the same cycle.
- Refresh counter:
  - Free-runs 0..REFRESH_CYCLES-1 and wraps.
  - At the terminal count, the display word <= peak_mode ? peak : live, using the register values before that edge.
  - disp_update pulses for one clock in the following cycle if the new word differs from the old one.
  - Display latency from a sample: up to REFRESH_CYCLES+1 clocks.
- peak_mode changes take effect only at the next refresh; there is no immediate update.
- Hex0–3 are registered and change only on refresh, reset or clear. On clear, the display word is zeroed immediately.

Optional Feature:
- Macro: AUDIO_PEAK_CLIP_EN.
- Defined:
  - clip_led is set on any sample_valid with abs >= CLIP_THRESH.
  - It stays set until clear or reset, and is not affected by decay or peak_mode.
  - Set has priority over clear in the same cycle only when sample_valid and abs >= CLIP_THRESH coincide with clear=0. With clear=1, clear wins.
- Undefined: no clip logic is built; clip_led is driven constant 0 and CLIP_THRESH is unused.

Test Plan:
- Parameters for all scenarios: HOLD_CYCLES=4, DECAY_CYCLES=2, DECAY_STEP=16, REFRESH_CYCLES=8.
- Reset: hold Reset_n=0 for 2 clocks with sample_valid=1, sample=16'h1234 → Hex0–3=0, clip_led=0, disp_update=0. After release, the first refresh with peak_mode=0 shows only a value sampled after release.
- Live display: peak_mode=0, one sample 16'hBEEF → at the next refresh Hex3..Hex0 = B,E,E,F and disp_update pulses once. Identical next refresh → no pulse.
- Peak/abs: peak_mode=1, samples 16'hFF00 (abs 0x0100) then 16'h0080 → peak=0x0100 and HOLD restarts only on the first sample. Sample 16'h8000 → peak=0x7FFF.
- Hold/decay: peak=0x0030 with no further samples → HOLD for 4 clocks, then decrements to 0x0020, 0x0010, 0x0000 every 2 clocks → IDLE. A sample of 0x0025 during decay → peak=0x0025, state HOLD.
- Clear priority: clear=1 with sample_valid=1, sample=16'h7FFF in the same cycle → peak=0, IDLE, display word=0, clip_led=0.
- Clip (AUDIO_PEAK_CLIP_EN defined): sample 16'h7F00 → clip_led=1 and stays 1 through full decay. A subsequent clear → 0. Without the macro, the same stimulus → clip_led stays 0.
